// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// pc_gen_pkg : instruction-class encoding and reset-PC default for pc_gen
// Rev 1.0
// ============================================================================
package pc_gen_pkg;

  typedef enum logic [1:0] {
    S_NONE  = 2'd0,
    S_BEQ   = 2'd1,
    S_J_JAL = 2'd2,
    S_JR    = 2'd3
  } instr_class_e;

  localparam logic [31:0] c_reset_pc_def = 32'h0000_3000;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
// pc_gen_if : control/datapath inputs and PC/RAS outputs of pc_gen
// Rev 1.0
// ============================================================================
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic               stall;
  instr_class_e       s;
  logic               is_link;
  logic               is_ret;
  logic [25:0]        instr_index;
  logic [XLEN-1:0]    offset;
  logic [XLEN-1:0]    a;
  logic               zero;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    pc_plus4;
  logic [XLEN-1:0]    npc;
  logic [XLEN-1:0]    ras_top;
  logic               ras_valid;
  logic               ras_mispredict;
  logic [CNT_W-1:0]   mispred_cnt;

  modport master (
    output stall, s, is_link, is_ret, instr_index, offset, a, zero,
    input  pc, pc_plus4, npc, ras_top, ras_valid, ras_mispredict, mispred_cnt
  );

  modport slave (
    input  stall, s, is_link, is_ret, instr_index, offset, a, zero,
    output pc, pc_plus4, npc, ras_top, ras_valid, ras_mispredict, mispred_cnt
  );
endinterface : pc_gen_if
`default_nettype wire

// File: rtl/pc_gen_ras_stack.sv
`default_nettype none
// ============================================================================
// ras_stack : circular return-address stack, oldest entry overwritten when full
// Rev 1.0
// ============================================================================
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            push,
  input  wire logic            pop,
  input  wire logic            replace,
  input  wire logic [XLEN-1:0] din,
  output logic      [XLEN-1:0] top,
  output logic                 valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_prev;
  logic            w_nonempty;

  assign w_prev     = r_ptr - PW'(1);
  assign w_nonempty = (r_count != '0);
  assign top        = r_mem[w_prev];
  assign valid      = w_nonempty;

  // Replace wins over pop; replace on an empty stack degrades to a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (replace && w_nonempty) begin
      r_mem[w_prev] <= din;
    end else if (push || replace) begin
      r_mem[r_ptr] <= din;
      r_ptr        <= r_ptr + PW'(1);
      if (r_count != CW'(DEPTH)) r_count <= r_count + CW'(1);
    end else if (pop && w_nonempty) begin
      r_ptr   <= w_prev;
      r_count <= r_count - CW'(1);
    end
  end
endmodule : ras_stack
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// pc_gen : PC register, next-PC select, return-address prediction and
//          saturating mispredict counter.   Rev 1.0
// ============================================================================
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(c_reset_pc_def),
  parameter int              RAS_DEPTH = 8,
  parameter int              CNT_W     = 16
) (
  input wire logic clk,
  input wire logic rst,
  pc_gen_if.slave  bus
);
  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_npc;
  logic [XLEN-1:0]  w_ras_top;
  logic             w_ras_valid;
  logic             w_adv;
  logic             w_push;
  logic             w_pop;
  logic             w_replace;
  logic             w_mispredict;

  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_adv      = !rst && !bus.stall;

  always_comb begin
    w_npc = w_pc_plus4;
    unique case (bus.s)
      S_NONE:  w_npc = w_pc_plus4;
      S_BEQ:   w_npc = bus.zero ? (w_pc_plus4 + (bus.offset << 2)) : w_pc_plus4;
      S_J_JAL: w_npc = {w_pc_plus4[XLEN-1:28], bus.instr_index, 2'b00};
      S_JR:    w_npc = bus.a;
      default: w_npc = w_pc_plus4;
    endcase
  end

  assign w_push    = w_adv && (bus.s == S_J_JAL) && bus.is_link;
  assign w_replace = w_adv && (bus.s == S_JR) && bus.is_link;
  assign w_pop     = w_adv && (bus.s == S_JR) && bus.is_ret;

  // Prediction only feeds the mispredict flag; the real target always steers.
  assign w_mispredict = (bus.s == S_JR) && bus.is_ret &&
                        !(w_ras_valid && (w_ras_top == bus.a));

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .XLEN  (XLEN)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .pop     (w_pop),
    .replace (w_replace),
    .din     (w_pc_plus4),
    .top     (w_ras_top),
    .valid   (w_ras_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_PC;
      r_cnt <= '0;
    end else if (w_adv) begin
      r_pc <= w_npc;
      if (w_mispredict && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.pc             = r_pc;
  assign bus.pc_plus4       = w_pc_plus4;
  assign bus.npc            = w_npc;
  assign bus.ras_top        = w_ras_top;
  assign bus.ras_valid      = w_ras_valid;
  assign bus.ras_mispredict = w_mispredict;
  assign bus.mispred_cnt    = r_cnt;
endmodule : pc_gen
`default_nettype wire
